// File: rtl/fdiv_issue_ctrl.sv
// Issue-side controller for the Newton-Raphson FP divider: holds one request,
// pulses the divider start, counts fixed latency and writes the quotient back.
// Optional protocol monitor on div_busy: define FDIV_PROTO_CHECK_EN.
module fdiv_issue_ctrl #(
  parameter int unsigned WB_LAT = 18
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [1:0]  i_req_rm,
  input  logic [4:0]  i_req_rd,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  output logic [1:0]  o_div_rm,
  output logic        o_div_fdiv,
  output logic        o_div_ena,
  input  logic        i_div_busy,
  input  logic [31:0] i_div_s,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  output logic        o_raw_hazard,
  output logic        o_stall,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_rd,
`ifdef FDIV_PROTO_CHECK_EN
  output logic [31:0] o_wb_data,
  output logic        o_proto_err
`else
  output logic [31:0] o_wb_data
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned MW = 2;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(WB_LAT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [MW-1:0] r_rm;
  logic [RW-1:0] r_rd;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_capture;
  logic          w_rd_match;

  // State and cycle counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand/destination hold registers, loaded only on acceptance
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_a  <= '0;
      r_b  <= '0;
      r_rm <= '0;
      r_rd <= '0;
    end else if (w_capture) begin
      r_a  <= i_req_a;
      r_b  <= i_req_b;
      r_rm <= i_req_rm;
      r_rd <= i_req_rd;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_capture   = 1'b0;
    o_req_ready = 1'b0;
    o_div_fdiv  = 1'b0;
    o_div_ena   = 1'b0;
    o_wb_en     = 1'b0;
    o_wb_rd     = '0;
    o_wb_data   = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_div_fdiv  = 1'b1;
        o_div_ena   = 1'b1;
        w_cnt_nxt   = CW'(1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_div_ena = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        o_div_ena   = 1'b1;
        o_wb_en     = 1'b1;
        o_wb_rd     = r_rd;
        o_wb_data   = i_div_s;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_div_a  = r_a;
  assign o_div_b  = r_b;
  assign o_div_rm = r_rm;

  // x0 is never a real destination, so it cannot create a hazard
  assign w_rd_match   = (i_id_rs1 == r_rd) || (i_id_rs2 == r_rd);
  assign o_raw_hazard = (r_state != S_IDLE) && (r_rd != '0) && w_rd_match;
  assign o_stall      = o_raw_hazard || (i_req_valid && !o_req_ready);

`ifdef FDIV_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_proto_viol;

  // Divider must be busy right after the start pulse and idle by writeback
  assign w_proto_viol = ((r_state == S_WAIT) && (r_cnt == CW'(1)) && !i_div_busy) ||
                        ((r_state == S_WB) && i_div_busy);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_proto_err <= 1'b0;
    end else if (w_proto_viol) begin
      r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;
`else
  logic w_unused_busy;
  assign w_unused_busy = i_div_busy;
`endif

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed bench for fdiv_issue_ctrl; a stub divider returns fixed quotients
// for the operand pairs used here. Define FDIV_PROTO_CHECK_EN to cover proto_err.
module tb_fdiv_issue_ctrl;

  localparam int unsigned LAT = 18;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_rm;
  logic [4:0]  req_rd;
  logic [31:0] div_a, div_b;
  logic [1:0]  div_rm;
  logic        div_fdiv, div_ena, div_busy;
  logic [31:0] div_s;
  logic [4:0]  id_rs1, id_rs2;
  logic        raw_hazard, stall, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy_mode;
`ifdef FDIV_PROTO_CHECK_EN
  logic        proto_err;
`endif

  int total = 0;
  int bad   = 0;

  fdiv_issue_ctrl #(.WB_LAT(LAT)) dut (
    .clk(clk), .clrn(clrn),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_rm(req_rm), .i_req_rd(req_rd),
    .o_div_a(div_a), .o_div_b(div_b), .o_div_rm(div_rm),
    .o_div_fdiv(div_fdiv), .o_div_ena(div_ena),
    .i_div_busy(div_busy), .i_div_s(div_s),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .o_raw_hazard(raw_hazard), .o_stall(stall),
    .o_wb_en(wb_en), .o_wb_rd(wb_rd),
`ifdef FDIV_PROTO_CHECK_EN
    .o_wb_data(wb_data), .o_proto_err(proto_err)
`else
    .o_wb_data(wb_data)
`endif
  );

  always #5 clk = ~clk;

  // Stub divider: fixed quotients for the operand pairs used in this bench
  function automatic logic [31:0] stub_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: stub_div = 32'h40400000; // 6/2
      64'h3F800000_00000000: stub_div = 32'h7F800000; // 1/0
      64'h00000000_00000000: stub_div = 32'h7FC00000; // 0/0
      64'h41200000_40A00000: stub_div = 32'h40000000; // 10/5
      64'h42280000_40400000: stub_div = 32'h41600000; // 42/3
      default:               stub_div = 32'hDEADBEEF;
    endcase
  endfunction

  assign div_s    = stub_div(div_a, div_b);
  // Well-behaved divider is busy after the start pulse until writeback
  assign div_busy = busy_mode & div_ena & ~div_fdiv & ~wb_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  // Issue one op from IDLE and follow it to writeback; called at a negedge in IDLE
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [4:0] rd,
                        output int wb_t, output int haz_cnt,
                        output logic [31:0] data, output logic [4:0] rdo);
    int fd_cnt;
    fd_cnt  = 0;
    haz_cnt = 0;
    wb_t    = -1;
    data    = '0;
    rdo     = '0;
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_rm = rm; req_rd = rd;
    @(negedge clk);
    check({tag, ".issue_a"}, div_a, a);
    check({tag, ".issue_b"}, div_b, b);
    check({tag, ".issue_rm"}, 32'(div_rm), 32'(rm));
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_rm = ~rm; req_rd = ~rd;
    for (int t = 0; t <= 40; t++) begin
      if (div_fdiv) fd_cnt++;
      if (raw_hazard && stall) haz_cnt++;
      if (wb_en) begin
        wb_t = t;
        data = wb_data;
        rdo  = wb_rd;
        check({tag, ".wb_hold_a"}, div_a, a);
        break;
      end
      @(negedge clk);
    end
    check({tag, ".fdiv_pulses"}, 32'(fd_cnt), 32'd1);
    @(negedge clk);
    check({tag, ".post_ready"}, {29'd0, req_ready, wb_en, div_ena}, {29'd0, 1'b1, 1'b0, 1'b0});
    check({tag, ".idle_keep_a"}, div_a, a);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [4:0]  rd;
    logic [31:0] exp_q;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int          wb_t, haz, t_fd2, t_wb1, t_wb2, n_wb, n_fd, n_we;
    logic [31:0] d, d1, d2;
    logic [4:0]  r, r1, r2;

    vecs[0] = '{32'h40C00000, 32'h40000000, 2'd0, 5'd3,  32'h40400000};
    vecs[1] = '{32'h3F800000, 32'h00000000, 2'd1, 5'd8,  32'h7F800000};
    vecs[2] = '{32'h00000000, 32'h00000000, 2'd2, 5'd17, 32'h7FC00000};
    vecs[3] = '{32'h41200000, 32'h40A00000, 2'd3, 5'd31, 32'h40000000};

    busy_mode = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_rm = '0; req_rd = '0;
    id_rs1 = '0; id_rs2 = '0;
    clrn = 1'b0;
    #1;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.ctl", {27'd0, div_fdiv, div_ena, wb_en, raw_hazard, stall}, 32'd0);
    check("rst.ops", div_a | div_b | 32'(div_rm) | 32'(wb_rd) | wb_data, 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // Table-driven single ops
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].rd, wb_t, haz, d, r);
      check($sformatf("vec%0d.latency", i), 32'(wb_t), 32'(LAT));
      check($sformatf("vec%0d.wb_rd", i), 32'(r), 32'(vecs[i].rd));
      check($sformatf("vec%0d.wb_data", i), d, vecs[i].exp_q);
    end

    // Back-to-back: second request held through the first op
    req_valid = 1'b1; req_a = 32'h42280000; req_b = 32'h40400000; req_rm = 2'd1; req_rd = 5'd5;
    @(negedge clk);
    req_a = 32'h40C00000; req_b = 32'h40000000; req_rm = 2'd0; req_rd = 5'd7;
    t_fd2 = -1; t_wb1 = -1; t_wb2 = -1; n_wb = 0; n_fd = 0;
    d1 = '0; d2 = '0; r1 = '0; r2 = '0;
    for (int t = 0; t <= 60; t++) begin
      if (t == 1) check("b2b.wait_ready_stall", {30'd0, req_ready, stall}, 32'd1);
      if (div_fdiv) begin
        n_fd++;
        if (n_fd == 2) begin t_fd2 = t; req_valid = 1'b0; end
      end
      if (wb_en) begin
        n_wb++;
        if (n_wb == 1) begin
          t_wb1 = t; d1 = wb_data; r1 = wb_rd;
          check("b2b.wb_not_ready", 32'(req_ready), 32'd0);
        end else begin
          t_wb2 = t; d2 = wb_data; r2 = wb_rd;
          break;
        end
      end
      @(negedge clk);
    end
    check("b2b.wb1_t", 32'(t_wb1), 32'(LAT));
    check("b2b.fdiv2_t", 32'(t_fd2), 32'(LAT + 2));
    check("b2b.wb_spacing", 32'(t_wb2 - t_wb1), 32'(LAT + 2));
    check("b2b.wb1", {d1[26:0], r1}, {27'h1600000, 5'd5});
    check("b2b.wb2", {d2[26:0], r2}, {27'h0400000, 5'd7});
    @(negedge clk);

    // RAW hazard on pending rd=3, then rd=0 never hazards
    id_rs1 = 5'd3;
    check("raw.idle", {30'd0, raw_hazard, stall}, 32'd0);
    run_op("raw3", 32'h40C00000, 32'h40000000, 2'd0, 5'd3, wb_t, haz, d, r);
    check("raw3.haz_cycles", 32'(haz), 32'(LAT + 1));
    check("raw3.after_wb", {30'd0, raw_hazard, stall}, 32'd0);
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    run_op("raw0", 32'h40C00000, 32'h40000000, 2'd0, 5'd0, wb_t, haz, d, r);
    check("raw0.haz_cycles", 32'(haz), 32'd0);

    // Reset mid-flight at cnt==7
    id_rs1 = 5'd9;
    req_valid = 1'b1; req_a = 32'h41200000; req_b = 32'h40A00000; req_rm = 2'd2; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.issue", 32'(div_fdiv), 32'd1);
    repeat (7) @(negedge clk);
    check("abort.pre_haz", 32'(raw_hazard), 32'd1);
    clrn = 1'b0;
    #1;
    check("abort.ready", 32'(req_ready), 32'd1);
    check("abort.ctl", {27'd0, div_fdiv, div_ena, wb_en, raw_hazard, stall}, 32'd0);
    check("abort.ops", div_a | div_b | 32'(div_rm) | 32'(wb_rd) | wb_data, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    n_we = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (wb_en || !req_ready) n_we++;
    end
    check("abort.no_wb", 32'(n_we), 32'd0);

`ifdef FDIV_PROTO_CHECK_EN
    check("proto.clean", 32'(proto_err), 32'd0);
    busy_mode = 1'b0;
    req_valid = 1'b1; req_a = 32'h40C00000; req_b = 32'h40000000; req_rm = 2'd0; req_rd = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("proto.first_wait", 32'(proto_err), 32'd0);
    @(negedge clk);
    check("proto.set", 32'(proto_err), 32'd1);
    repeat (LAT + 4) @(negedge clk);
    check("proto.sticky", {30'd0, proto_err, req_ready}, 32'd3);
    busy_mode = 1'b1;
    do_reset();
    check("proto.cleared", 32'(proto_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
